sipo_rx9: RTL and testbench

- Serial-to-parallel frame receiver for the ping-pong board's 9-bit serial links.
- Accepts an MSB-first bit stream qualified by a bit-enable and a frame-start marker.
- Assembles WIDTH bits and presents the word on a held parallel output with a one-cycle valid pulse.
- Sits on the receive end of the 9-bit load/shift transmitters and feeds the game-state and display logic.

---
 rtl/sipo_rx9.sv | 104 ++++++++++
 tb/tb_sipo_rx9.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sipo_rx9.sv
// Serial-to-parallel frame receiver: assembles WIDTH MSB-first bits into a held
// parallel word with a one-cycle valid pulse, flagging frames aborted by a new start.
module sipo_rx9 #(
    parameter int WIDTH = 9,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_in,
    input  logic             bit_en,
    input  logic             start,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             busy,
    output logic             frame_err,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] p_out_d;
    logic [CNT_W-1:0] cnt_d;
    logic             valid_d, err_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fresh;
    logic [CNT_W-1:0] cnt_inc;

    assign shifted = WIDTH'({shift_q, s_in});
    assign fresh   = WIDTH'(s_in);
    assign cnt_inc = bit_cnt + CNT_W'(1);
    assign busy    = (state_q == RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            p_out     <= '0;
            p_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt   <= cnt_d;
            p_out     <= p_out_d;
            p_valid   <= valid_d;
            frame_err <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = bit_cnt;
        p_out_d = p_out;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // A single-bit frame completes on its start bit without entering RECV.
                        if (WIDTH == 1) begin
                            shift_d = fresh;
                            p_out_d = fresh;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            shift_d = fresh;
                            cnt_d   = CNT_W'(1);
                            state_d = RECV;
                        end
                    end
                end
                RECV: begin
                    if (start) begin
                        shift_d = fresh;
                        cnt_d   = CNT_W'(1);
                        err_d   = 1'b1;
                    end else if (cnt_inc == LAST) begin
                        shift_d = shifted;
                        p_out_d = shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        shift_d = shifted;
                        cnt_d   = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_rx9.sv
// Self-checking bench for sipo_rx9: directed scenarios plus random traffic scored
// against a queue-based frame model; a second WIDTH=1 instance is checked directly.
module tb_sipo_rx9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_in = 1'b0, bit_en = 1'b0, start = 1'b0;
    logic [8:0] p_out;
    logic       p_valid, busy, frame_err;
    logic [3:0] bit_cnt;

    logic       s_in1 = 1'b0, bit_en1 = 1'b0, start1 = 1'b0;
    logic [0:0] p_out1;
    logic       p_valid1, busy1, frame_err1;
    logic [3:0] bit_cnt1;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: bits of the frame in progress, plus expected registered outputs.
    int         bits[$];
    logic [8:0] exp_pout = '0;
    logic       exp_valid = 1'b0;
    logic       exp_err = 1'b0;

    always #5 clk = ~clk;

    sipo_rx9 #(.WIDTH(9), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .bit_en(bit_en), .start(start),
        .p_out(p_out), .p_valid(p_valid), .busy(busy), .frame_err(frame_err),
        .bit_cnt(bit_cnt)
    );

    sipo_rx9 #(.WIDTH(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_in(s_in1), .bit_en(bit_en1), .start(start1),
        .p_out(p_out1), .p_valid(p_valid1), .busy(busy1), .frame_err(frame_err1),
        .bit_cnt(bit_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".p_out"},     32'(p_out),     32'(exp_pout));
        chk({tag, ".p_valid"},   32'(p_valid),   32'(exp_valid));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(exp_err));
        chk({tag, ".busy"},      32'(busy),      32'(bits.size() > 0));
        chk({tag, ".bit_cnt"},   32'(bit_cnt),   32'(bits.size()));
    endtask

    task automatic model_step(input logic en, input logic st, input logic sin);
        logic [8:0] w;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (en) begin
            if (st) begin
                if (bits.size() > 0) exp_err = 1'b1;
                bits.delete();
                bits.push_back(int'(sin));
            end else if (bits.size() > 0) begin
                bits.push_back(int'(sin));
            end
            if (bits.size() == 9) begin
                w = '0;
                foreach (bits[i]) w = {w[7:0], bits[i][0]};
                exp_pout  = w;
                exp_valid = 1'b1;
                bits.delete();
            end
        end
    endtask

    task automatic step(input logic en, input logic st, input logic sin, input string tag);
        @(negedge clk);
        bit_en = en;
        start  = st;
        s_in   = sin;
        @(posedge clk);
        model_step(en, st, sin);
        #1;
        check_all(tag);
    endtask

    task automatic send_bits(input logic [8:0] w, input int nbits, input int gap, input string tag);
        for (int i = 0; i < nbits; i++) begin
            step(1'b1, i == 0, w[8-i], tag);
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'($urandom), 1'($urandom), {tag, ".gap"});
        end
    endtask

    task automatic step1(input logic en, input logic st, input logic sin);
        @(negedge clk);
        bit_en1 = en;
        start1  = st;
        s_in1   = sin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check_all("reset");
        chk("reset.w1.p_out", 32'(p_out1), 32'h0);
        chk("reset.w1.busy",  32'(busy1),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        send_bits(9'h1A5, 9, 0, "contig");
        step(1'b0, 1'b0, 1'b0, "contig.after");

        send_bits(9'h0F3, 9, 3, "gapped");

        send_bits(9'h1FF, 4, 0, "restart.pre");
        send_bits(9'h012, 9, 0, "restart");

        send_bits(9'h155, 9, 0, "b2b.a");
        send_bits(9'h0AA, 9, 0, "b2b.b");

        send_bits(9'h1C3, 5, 0, "rst.pre");
        @(negedge clk);
        bit_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        bits.delete();
        exp_pout  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        check_all("rst.async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'($urandom), "stray");
        send_bits(9'h07E, 9, 0, "post_rst");

        send_bits(9'h1B6, 8, 0, "abort_last.pre");
        send_bits(9'h0C9, 9, 1, "abort_last");

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), 1'($urandom), "random");

        step1(1'b1, 1'b1, 1'b1);
        chk("w1.p_out.1",   32'(p_out1),     32'h1);
        chk("w1.p_valid.1", 32'(p_valid1),   32'h1);
        chk("w1.busy.1",    32'(busy1),      32'h0);
        chk("w1.cnt.1",     32'(bit_cnt1),   32'h0);
        step1(1'b1, 1'b0, 1'b0);
        chk("w1.stray.valid", 32'(p_valid1), 32'h0);
        chk("w1.stray.p_out", 32'(p_out1),   32'h1);
        step1(1'b1, 1'b1, 1'b0);
        chk("w1.p_out.0",   32'(p_out1),     32'h0);
        chk("w1.p_valid.0", 32'(p_valid1),   32'h1);
        chk("w1.err",       32'(frame_err1), 32'h0);
        step1(1'b0, 1'b1, 1'b1);
        chk("w1.idle.valid", 32'(p_valid1),  32'h0);
        chk("w1.idle.busy",  32'(busy1),     32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
